// File: rtl/m1_mem_stage_if.sv
// m1_mem_stage_if: data-memory req/gnt/rvalid bus between the M1 stage and memory
interface m1_mem_stage_if #(parameter int XLEN = 32);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;
   modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   input dmem_gnt, dmem_rvalid, dmem_rdata);
   modport slave (input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/m1_mem_stage.sv
// m1_mem_stage: issues data-memory accesses, aligns/extends data and registers the M1/M2 bundle
module m1_mem_stage #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            flush,
   input  logic [XLEN-1:0] pc,
   input  logic [4:0]      rd,
   input  logic [4:0]      mem_op,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] operand2,
   input  logic [2:0]      wb_src,
   m1_mem_stage_if.master  dmem,
   output logic            stall_out,
   output logic            misalign_out,
   output logic [XLEN-1:0] misalign_addr,
   output logic [XLEN-1:0] m2_pc,
   output logic [4:0]      m2_rd,
   output logic [2:0]      m2_wb_src,
   output logic [XLEN-1:0] m2_data,
   output logic            m2_valid
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
   state_t r_state, w_next;
   logic w_access, w_word, w_half, w_mis, w_issue, w_mis_ev, w_cap;
   logic [XLEN-1:0] w_lane, w_load;

   assign w_access = mem_op[4];
   assign w_word   = mem_op[1];
   assign w_half   = mem_op[1:0] == 2'b01;
   assign w_mis    = w_access & ((w_half & result[0]) | (w_word & |result[1:0]));
   assign w_issue  = nrst & !flush & (r_state == IDLE) & w_access & !w_mis;
   assign w_mis_ev = !flush & (r_state == IDLE) & w_mis;

   assign dmem.dmem_we    = mem_op[3];
   assign dmem.dmem_addr  = {result[XLEN-1:2], 2'b00};
   assign dmem.dmem_be    = w_word ? 4'b1111 : (w_half ? 4'b0011 : 4'b0001) << result[1:0];
   assign dmem.dmem_wdata = w_word ? operand2 : w_half ? {2{operand2[15:0]}} : {4{operand2[7:0]}};

   assign w_lane = dmem.dmem_rdata >> {result[1:0], 3'b000};
   assign w_load = w_word ? dmem.dmem_rdata
                 : w_half ? {{16{~mem_op[2] & w_lane[15]}}, w_lane[15:0]}
                 : {{24{~mem_op[2] & w_lane[7]}}, w_lane[7:0]};

   // next state, request/stall and M1/M2 capture enable; reset inhibits any access
   always_comb begin
      w_next        = r_state;
      dmem.dmem_req = 1'b0;
      stall_out     = 1'b0;
      w_cap         = 1'b0;
      case (r_state)
         IDLE: begin
            dmem.dmem_req = w_issue;
            stall_out     = w_issue;
            w_cap         = !w_access & !flush;
            w_next        = w_issue ? (dmem.dmem_gnt ? WAIT : REQ) : IDLE;
         end
         REQ: begin
            dmem.dmem_req = !flush;
            stall_out     = !flush;
            w_next        = flush ? IDLE : dmem.dmem_gnt ? WAIT : REQ;
         end
         WAIT: begin
            stall_out = !dmem.dmem_rvalid;
            w_cap     = dmem.dmem_rvalid & !flush;
            w_next    = dmem.dmem_rvalid ? IDLE : flush ? DRAIN : WAIT;
         end
         default: begin
            stall_out = !dmem.dmem_rvalid;
            w_next    = dmem.dmem_rvalid ? IDLE : DRAIN;
         end
      endcase
      if (!nrst) begin
         dmem.dmem_req = 1'b0;
         stall_out     = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!nrst) r_state <= IDLE;
      else r_state <= w_next;
   end

   // M1/M2 boundary: live instruction on capture, bubble otherwise
   always_ff @(posedge clk) begin
      if (!nrst || !w_cap) begin
         m2_pc     <= '0;
         m2_rd     <= '0;
         m2_wb_src <= '0;
         m2_data   <= '0;
         m2_valid  <= 1'b0;
      end else begin
         m2_pc     <= pc;
         m2_rd     <= rd;
         m2_wb_src <= wb_src;
         m2_data   <= (r_state == WAIT && !mem_op[3]) ? w_load : result;
         m2_valid  <= (r_state == WAIT) | (|pc) | (|rd);
      end
   end

   // misaligned-access exception pulse and faulting address
   always_ff @(posedge clk) begin
      if (!nrst) begin
         misalign_out  <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_out <= w_mis_ev;
         if (w_mis_ev) misalign_addr <= result;
      end
   end
endmodule

// File: tb/tb_m1_mem_stage.sv
// tb_m1_mem_stage: randomized and directed checks of m1_mem_stage against a behavioural model
module tb_m1_mem_stage;
   logic clk = 1'b0, nrst, flush;
   logic [31:0] pc, result, operand2;
   logic [4:0] rd, mem_op;
   logic [2:0] wb_src;
   logic stall_out, misalign_out, m2_valid;
   logic [31:0] misalign_addr, m2_pc, m2_data;
   logic [4:0] m2_rd;
   logic [2:0] m2_wb_src;
   int n_chk = 0, n_pass = 0;

   m1_mem_stage_if #(.XLEN(32)) dif ();

   m1_mem_stage #(.XLEN(32)) dut (
      .clk(clk), .nrst(nrst), .flush(flush), .pc(pc), .rd(rd), .mem_op(mem_op),
      .result(result), .operand2(operand2), .wb_src(wb_src), .dmem(dif.master),
      .stall_out(stall_out), .misalign_out(misalign_out), .misalign_addr(misalign_addr),
      .m2_pc(m2_pc), .m2_rd(m2_rd), .m2_wb_src(m2_wb_src), .m2_data(m2_data), .m2_valid(m2_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [4:0] mop);
      return mop[1] ? 4 : mop[0] ? 2 : 1;
   endfunction

   function automatic logic [31:0] ref_load(input logic [4:0] mop, input logic [31:0] a, input logic [31:0] d);
      int n = nbytes(mop);
      longint v = (longint'(d) >> (8 * int'(a[1:0]))) % (longint'(1) << (8 * n));
      if (!mop[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_be(input logic [4:0] mop, input logic [31:0] a);
      int n = nbytes(mop);
      return 32'(((1 << n) - 1) << (n == 4 ? 0 : int'(a[1:0])));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [4:0] mop, input logic [31:0] v);
      int n = nbytes(mop);
      return n == 1 ? v[7:0] * 32'h0101_0101 : n == 2 ? v[15:0] * 32'h0001_0001 : v;
   endfunction

   task automatic set_in(input logic [31:0] p, input logic [4:0] r, input logic [4:0] mop,
                         input logic [31:0] res, input logic [31:0] op2, input logic [2:0] wb);
      pc = p; rd = r; mem_op = mop; result = res; operand2 = op2; wb_src = wb;
   endtask

   task automatic do_op(input logic [31:0] p, input logic [4:0] r, input logic [4:0] mop,
                        input logic [31:0] res, input logic [31:0] op2, input logic [2:0] wb,
                        input int gd, input int rdl, input logic [31:0] rdat);
      logic mis;
      int st;
      set_in(p, r, mop, res, op2, wb);
      flush = 1'b0; dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0;
      #1;
      mis = mop[4] && ((nbytes(mop) == 2 && res[0]) || (nbytes(mop) == 4 && res[1:0] != 2'b00));
      if (!mop[4] || mis) begin
         chk("req_noacc", 32'(dif.dmem_req), 32'd0);
         chk("stall_noacc", 32'(stall_out), 32'd0);
         tick();
         chk("mis_out", 32'(misalign_out), 32'(mis));
         chk("m2_valid", 32'(m2_valid), 32'(!mis && (p != 0 || r != 0)));
         if (mis) chk("mis_addr", misalign_addr, res);
         else begin
            chk("m2_data_alu", m2_data, res);
            chk("m2_pc", m2_pc, p);
            chk("m2_rd", 32'(m2_rd), 32'(r));
            chk("m2_wb", 32'(m2_wb_src), 32'(wb));
         end
      end else begin
         st = 0;
         for (int k = 0; k <= gd; k++) begin
            chk("req", 32'(dif.dmem_req), 32'd1);
            chk("we", 32'(dif.dmem_we), 32'(mop[3]));
            chk("addr", dif.dmem_addr, res & 32'hFFFF_FFFC);
            chk("be", 32'(dif.dmem_be), ref_be(mop, res));
            chk("wdata", dif.dmem_wdata, ref_wdata(mop, op2));
            st += int'(stall_out);
            dif.dmem_gnt = (k == gd);
            tick();
            dif.dmem_gnt = 1'b0;
         end
         for (int k = 0; k < rdl; k++) begin
            #1;
            chk("req_wait", 32'(dif.dmem_req), 32'd0);
            st += int'(stall_out);
            tick();
         end
         dif.dmem_rvalid = 1'b1; dif.dmem_rdata = rdat;
         #1;
         chk("stall_rvalid", 32'(stall_out), 32'd0);
         tick();
         dif.dmem_rvalid = 1'b0;
         chk("stall_cycles", 32'(st), 32'(gd + 1 + rdl));
         chk("m2_valid_mem", 32'(m2_valid), 32'd1);
         chk("m2_data_mem", m2_data, mop[3] ? res : ref_load(mop, res, rdat));
         chk("m2_pc_mem", m2_pc, p);
         chk("m2_rd_mem", 32'(m2_rd), 32'(r));
         chk("mis_mem", 32'(misalign_out), 32'd0);
      end
   endtask

   initial begin
      logic [4:0] mop;
      logic [31:0] res, p;
      logic [4:0] r;
      nrst = 1'b0; flush = 1'b0;
      dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = '0;
      set_in(32'h40, 5'd1, 5'b10010, 32'h100, 32'h0, 3'd1);
      tick(); tick();
      chk("rst_req", 32'(dif.dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_out), 32'd0);
      chk("rst_m2_valid", 32'(m2_valid), 32'd0);
      chk("rst_m2_pc", m2_pc, 32'd0);
      chk("rst_mis", 32'(misalign_out), 32'd0);
      nrst = 1'b1;
      do_op(32'h1000, 5'd1, 5'b10010, 32'h100, 32'h0, 3'd2, 0, 0, 32'hDEAD_BEEF);
      chk("lw_const", m2_data, 32'hDEAD_BEEF);
      do_op(32'h1004, 5'd2, 5'b10000, 32'h103, 32'h0, 3'd2, 0, 0, 32'h80FF_0000);
      chk("lb_const", m2_data, 32'hFFFF_FF80);
      do_op(32'h1008, 5'd3, 5'b10100, 32'h103, 32'h0, 3'd2, 0, 1, 32'h80FF_0000);
      chk("lbu_const", m2_data, 32'h0000_0080);
      do_op(32'h100C, 5'd0, 5'b11001, 32'h202, 32'h1234_ABCD, 3'd0, 3, 0, 32'h0);
      do_op(32'h1010, 5'd4, 5'b10010, 32'h101, 32'h0, 3'd2, 0, 0, 32'h0);
      // flush while waiting for the response: drain, bubble, then a normal ALU op
      set_in(32'h2000, 5'd3, 5'b10010, 32'h100, 32'h0, 3'd2);
      dif.dmem_gnt = 1'b1; #1;
      chk("fl_req", 32'(dif.dmem_req), 32'd1);
      tick(); dif.dmem_gnt = 1'b0; flush = 1'b1; #1;
      chk("fl_wait_stall", 32'(stall_out), 32'd1);
      tick(); flush = 1'b0; #1;
      chk("drain_stall", 32'(stall_out), 32'd1);
      chk("drain_req", 32'(dif.dmem_req), 32'd0);
      tick(); dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'h55;
      tick(); dif.dmem_rvalid = 1'b0;
      chk("drain_bubble_v", 32'(m2_valid), 32'd0);
      chk("drain_bubble_d", m2_data, 32'd0);
      do_op(32'h2004, 5'd5, 5'b00000, 32'h7, 32'h0, 3'd1, 0, 0, 32'h0);
      // flush in REQ with a coincident gnt that must be ignored
      set_in(32'h3000, 5'd6, 5'b10010, 32'h300, 32'h0, 3'd2);
      tick(); flush = 1'b1; dif.dmem_gnt = 1'b1; #1;
      chk("fl_req_drop", 32'(dif.dmem_req), 32'd0);
      tick(); flush = 1'b0; dif.dmem_gnt = 1'b0;
      chk("fl_req_bubble", 32'(m2_valid), 32'd0);
      do_op(32'h3004, 5'd7, 5'b10010, 32'h302, 32'h0, 3'd2, 0, 0, 32'h0);
      // flush together with rvalid in WAIT goes straight to IDLE
      set_in(32'h3100, 5'd8, 5'b10010, 32'h400, 32'h0, 3'd2);
      dif.dmem_gnt = 1'b1; tick(); dif.dmem_gnt = 1'b0;
      flush = 1'b1; dif.dmem_rvalid = 1'b1; tick(); flush = 1'b0; dif.dmem_rvalid = 1'b0;
      chk("fl_rv_bubble", 32'(m2_valid), 32'd0);
      do_op(32'h3104, 5'd9, 5'b00000, 32'h9, 32'h0, 3'd3, 0, 0, 32'h0);
      // reset while in REQ
      set_in(32'h4000, 5'd10, 5'b10010, 32'h500, 32'h0, 3'd2);
      tick(); nrst = 1'b0; #1;
      chk("rst_req_req", 32'(dif.dmem_req), 32'd0);
      chk("rst_req_stall", 32'(stall_out), 32'd0);
      tick(); nrst = 1'b1;
      chk("rst_req_m2v", 32'(m2_valid), 32'd0);
      chk("rst_req_m2d", m2_data, 32'd0);
      chk("rst_req_m2pc", m2_pc, 32'd0);
      do_op(32'h4004, 5'd11, 5'b10010, 32'h501, 32'h0, 3'd2, 0, 0, 32'h0);
      // stale rvalid in IDLE
      set_in(32'h5000, 5'd12, 5'b00000, 32'h1234, 32'h0, 3'd1);
      dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'hFFFF_FFFF; tick(); dif.dmem_rvalid = 1'b0;
      chk("stale_rv", m2_data, 32'h1234);
      for (int i = 0; i < 200; i++) begin
         mop = 5'($urandom);
         if ($urandom_range(0, 3) != 0) mop[4] = 1'b1;
         res = $urandom;
         if ($urandom_range(0, 3) != 0) res[1:0] = mop[1] ? 2'b00 : mop[0] ? {res[1], 1'b0} : res[1:0];
         p = $urandom; r = 5'($urandom);
         if ($urandom_range(0, 7) == 0) begin p = '0; r = '0; end
         do_op(p, r, mop, res, $urandom, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/m1_mem_stage.md
Name: m1_mem_stage

Overview:
M1 pipeline stage, fed directly by the EX/M1 pipeline register. It issues data-memory loads and stores over a req/gnt/rvalid handshake, and checks alignment. It aligns store data and byte enables, sign- or zero-extends load data, and registers the writeback bundle into the M1/M2 boundary. While an access is outstanding it stalls the upstream pipeline.

Parameters:
XLEN, 32, datapath and address width

Ports:
clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
flush  input  1  kill the M1 instruction (trap/redirect)
pc  input  XLEN  instruction PC from EX/M1
rd  input  5  destination register
mem_op  input  5  [4]=access, [3]=store, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W); 0 = no access
result  input  XLEN  ALU result; effective address when mem_op[4]=1
operand2  input  XLEN  store data (rs2)
wb_src  input  3  writeback source select, passed through
dmem_req  output  1  request valid
dmem_we  output  1  1 = store
dmem_addr  output  XLEN  word-aligned address ({result[31:2],2'b0})
dmem_be  output  4  byte enables
dmem_wdata  output  XLEN  lane-shifted store data
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  response valid (load data or store ack)
dmem_rdata  input  XLEN  load data, full word
stall_out  output  1  hold EX/M1 and all earlier stages
misalign_out  output  1  one-cycle misaligned-access exception pulse
misalign_addr  output  XLEN  faulting address, valid with misalign_out
m2_pc  output  XLEN  registered PC
m2_rd  output  5  registered rd
m2_wb_src  output  3  registered wb_src
m2_data  output  XLEN  registered extended load data, or result for non-loads
m2_valid  output  1  registered; M2 holds a live instruction

Behaviour:
- Reset (nrst=0 at posedge): state=IDLE. All m2_* outputs, misalign_addr and misalign_out are 0. dmem_req=0 and stall_out=0 are driven combinationally from IDLE with access inhibited during reset.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE, no access (mem_op[4]=0): no request; stall_out=0. The M1/M2 register loads {pc, rd, wb_src, result}. m2_valid=1 if pc≠0 or rd≠0, else 0 (bubble).
- IDLE, access, aligned: dmem_req=1 combinationally in the same cycle; stall_out=1.
  - gnt=1 → WAIT.
  - gnt=0 → REQ.
- REQ: dmem_req stays 1 with stable addr, be, wdata and we. gnt=1 → WAIT. stall_out=1.
- WAIT: dmem_req=0, stall_out=1. On rvalid=1:
  - stall_out drops combinationally that cycle.
  - The M1/M2 register captures the completed instruction; m2_data = extended load data, or result for stores.
  - Next state IDLE.
- Stall timing: a zero-wait memory (gnt in IDLE, rvalid in the next cycle) costs exactly one stall cycle per access.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - No request is issued; misalign_out=1 for one cycle; misalign_addr=result.
  - M1/M2 is written with m2_valid=0; stall_out=0.
- Size 2'b11: treated as word.
- Byte enables: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
- Store data: wdata = operand2 shifted left by 8*addr[1:0]; byte and half are replicated into the selected lanes.
- Load extension: select the lane by addr[1:0], then zero-extend if mem_op[2]=1, else sign-extend. Address and size are taken from the held EX/M1 inputs, which stay stable under stall.
- flush:
  - In IDLE or REQ: the request is dropped immediately (dmem_req=0 that cycle); state IDLE. M1/M2 gets m2_valid=0 and all other m2_* cleared. A gnt arriving in that same cycle is ignored by the memory contract (req=0).
  - In WAIT: go to DRAIN; stall_out=1 is held.
  - In DRAIN: stall_out=1 is held; wait for rvalid, discard the data, write a bubble into M1/M2, then go to IDLE. Flush in DRAIN has no further effect.
  - flush with rvalid in the same WAIT cycle: the response is discarded, a bubble is written, and the state goes directly to IDLE.
- Reset in any state: immediate return to IDLE. The memory subsystem is reset by the same nrst, so no draining occurs.
- Stale responses: rvalid in IDLE or REQ is ignored.

Test Plan:
- Load, zero-wait: mem_op=5'b10010 (LW), result=0x100, rdata=0xDEADBEEF, gnt in cycle 0, rvalid in cycle 1 → req/be=4'b1111 for 1 cycle, stall_out=1 for 1 cycle, m2_data=0xDEADBEEF, m2_valid=1.
- Signed LB: mem_op=5'b10000, addr=0x103, rdata=0x80FF_0000 → be=4'b1000, m2_data=0xFFFF_FF80. Same with LBU (5'b10100) → 0x0000_0080.
- SH: addr=0x202, operand2=0x1234ABCD, gnt delayed 3 cycles → dmem_req high 4 cycles with stable addr=0x200, be=4'b1100, wdata=0xABCDABCD; stall_out high until the rvalid cycle.
- Misaligned LW at addr=0x101 → no dmem_req; misalign_out=1 for one cycle; misalign_addr=0x101; m2_valid=0; stall_out=0.
- flush in WAIT, rvalid 2 cycles later with rdata=0x55 → state DRAIN, stall_out held, M1/M2 gets a bubble (m2_valid=0, m2_data=0), then IDLE. A following ALU op (result=0x7) reaches m2_data=0x7.
- nrst=0 asserted in REQ → next cycle dmem_req=0, stall_out=0, all m2_* = 0, state IDLE.
